logistic_array_engine: RTL and testbench
========================================

# logistic_array_engine

Parametrised multi-channel logistic-map iterator: computes x(n+1) = mu·x(n)·(1 − x(n)) in unsigned fixed point for NCH independent channels over a programmable iteration count. All channels share one sequential shift-add multiplier. The block sits between the parameter registers (mu, iteration count, seed) and the pixel/colour logic, which reads per-channel results through a random-access read port. It adds start/busy/done handshaking, a wider mu range (0 ≤ mu < 8) and optional overflow saturation.

## Interface
Parameters:
- W, 16, fraction bits; x is W+1 bits (1.0 = 1<<W)
- NCH, 7, channel count (≥1)
- ITER_W, 9, width of iteration count
- CH_W, $clog2(NCH) (min 1), channel index width

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous, active-low reset
- start  in  1  begin run; sampled only in IDLE
- mu  in  W+3  unsigned, W fraction bits; latched at start
- times  in  ITER_W  iterations per channel; latched at start
- x0_base  in  W+1  seed; channel ch starts at x0_base + ch (mod 2^(W+1))
- busy  out  1  high from INIT through DONE cycle inclusive
- done  out  1  one-cycle pulse at run completion
- rd_ch  in  CH_W  read channel select
- rd_x  out  W+1  combinational read of result register rd_ch; 0 if rd_ch ≥ NCH

## Operation
- States: IDLE → INIT → M1S → M1W → M2S → M2W → WB → (M1S | DONE) → IDLE.
- IDLE: start=1 latches mu and times, goes to INIT. start while busy is ignored.
- INIT: loads x[ch] = x0_base + ch for all ch; clears ch and iteration counters. If times=0, goes to DONE; otherwise goes to M1S.
- M1S: issues go to the multiplier with a = x[ch], b = ONE − x[ch], both zero-extended to W+3 bits.
- M1W: waits for mult_done. On that cycle captures t = prod[2W+1:W] (W+2 bits) and goes to M2S.
- M2S: issues go with a = mu, b = t.
- M2W: waits for mult_done. On that cycle captures y.
  - raw y = prod[2W:W].
- WB: writes x[ch] = y.
  - If ch = NCH−1: ch returns to 0 and the iteration counter increments.
  - If the iteration counter then equals times: goes to DONE; otherwise goes to M1S.
- Channel order is channel-inner: iteration k runs for all channels before iteration k+1 starts.
- DONE: done=1 and busy=1 for one cycle, then IDLE. Results hold until the next INIT or reset.
- rd_x is live at all times; during a run it shows partially updated values.
- Inputs x[ch] > ONE wrap the (ONE − x) term modulo 2^(W+3). Callers must keep seeds ≤ ONE.
- Reset at any point, including mid-run:
  - state returns to IDLE;
  - all x[ch] clear to 0;
  - busy and done go to 0;
  - the multiplier aborts, with its done and product cleared.

## Timing
- Multiplier latency L = W+3 cycles: go at cycle t gives mult_done and a valid product at t+L.
- M1S+M1W take L+1 cycles; M2S+M2W take L+1 cycles; WB takes 1 cycle. Per channel-step cost: S = 2L+3 (41 at W=16).
- With start sampled at cycle 0:
  - INIT occurs at cycle 1;
  - done occurs at cycle 2 + times·NCH·S;
  - for times=0, done occurs at cycle 2.
- Reset values: busy=0, done=0, rd_x=0.

## Configuration
- LOGISTIC_SAT_EN defined: if the full product bits [2W+2:W] exceed ONE, y = ONE. x therefore stays in [0, 1.0].
- LOGISTIC_SAT_EN undefined: y is raw prod[2W:W] with no clamping, so it can exceed ONE when mu > 4.

## Structure
- logistic_pkg contains:
  - state enum;
  - ONE = 1<<W as a function of W;
  - width helpers (XW = W+1, MW = W+3).
- Sub-module logistic_seq_mult (parameter MW) is a radix-2 shift-add unsigned MW×MW multiplier with ports CLK, RST, go, a, b, prod[2MW−1:0], mult_done.
  - go while the multiplier is busy restarts it.

## Test plan
All scenarios use W=16, NCH=7.
- times=0, x0_base=0x08000, start: done at cycle 2; rd_x(ch) = 0x08000+ch for ch 0..6; rd_ch=7 reads 0.
- mu=0x40000 (4.0), x0_base=0x08000, times=1: channel 0 result 0x10000. With times=2: channel 0 result 0x00000.
- mu=0x60000 (6.0), x0_base=0x08000, times=1: channel 0 result 0x10000 with LOGISTIC_SAT_EN, 0x18000 without.
- times=3: busy high cycles 1..863, one-cycle done at 863. start pulses during busy change nothing.
- RST=0 mid-run at cycle 100 for one cycle: busy=0 next cycle, all rd_x=0. A fresh start then completes with the same results as a clean run.
- Random mu < 4.0 and seeds ≤ ONE, times 1..20: every channel matches a bit-exact reference model of the truncation rules above.

Source files
------------

// File: rtl/logistic_array_engine_pkg.sv
// logistic_pkg: FSM states and fixed-point width helpers for the logistic array engine
package logistic_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_M1S, S_M1W, S_M2S, S_M2W, S_WB, S_DONE
  } state_t;
  function automatic int xw_of(input int w);
    return w + 1;
  endfunction
  function automatic int mw_of(input int w);
    return w + 3;
  endfunction
  function automatic longint one_of(input int w);
    return longint'(1) << w;
  endfunction
endpackage

// File: rtl/logistic_array_engine_mult.sv
// logistic_seq_mult: radix-2 shift-add unsigned MWxMW multiplier, result MW cycles after go
module logistic_seq_mult #(
  parameter int MW = 19
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            go,
  input  logic [MW-1:0]   a,
  input  logic [MW-1:0]   b,
  output logic [2*MW-1:0] prod,
  output logic            mult_done
);
  localparam int CW = $clog2(MW + 1);
  logic [2*MW-1:0] mcand, acc, m_c, acc_n;
  logic [MW-1:0]   mplier, p_c;
  logic [CW-1:0]   cnt;
  logic            active, fin;
  // the go edge already performs the first partial-product step
  always_comb begin
    m_c   = go ? {{MW{1'b0}}, a} : mcand;
    p_c   = go ? b : mplier;
    acc_n = (go ? '0 : acc) + (p_c[0] ? m_c : '0);
    fin   = !go && cnt == CW'(MW - 1);
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      active    <= 1'b0;
      prod      <= '0;
      mult_done <= 1'b0;
    end else begin
      mult_done <= 1'b0;
      if (go || active) begin
        acc    <= acc_n;
        mcand  <= m_c << 1;
        mplier <= p_c >> 1;
        cnt    <= go ? CW'(1) : cnt + CW'(1);
        active <= !fin;
        if (fin) begin
          prod      <= acc_n;
          mult_done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/logistic_array_engine.sv
// logistic_array_engine: NCH-channel logistic-map iterator sharing one sequential multiplier
// LOGISTIC_SAT_EN clamps each new x to 1.0 when the scaled product overflows it.
module logistic_array_engine
  import logistic_pkg::*;
#(
  parameter int W      = 16,
  parameter int NCH    = 7,
  parameter int ITER_W = 9,
  parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [W+2:0]        mu,
  input  logic [ITER_W-1:0]   times,
  input  logic [W:0]          x0_base,
  output logic                busy,
  output logic                done,
  input  logic [CH_W-1:0]     rd_ch,
  output logic [W:0]          rd_x
);
  localparam int XW = xw_of(W);
  localparam int MW = mw_of(W);
  localparam logic [MW-1:0] ONE = MW'(one_of(W));
  state_t              state;
  logic [XW-1:0]       x [NCH];
  logic [MW-1:0]       mu_q, a_m, b_m;
  logic [ITER_W-1:0]   times_q, iter;
  logic [CH_W-1:0]     ch;
  logic [W+1:0]        t_q;
  logic [XW-1:0]       y_q, y_c;
  logic [2*MW-1:0]     prod;
  logic                mult_done, go, last, fin;
  logic                unused_bits;
  assign go          = state == S_M1S || state == S_M2S;
  assign last        = ch == CH_W'(NCH - 1);
  assign fin         = last && (iter + ITER_W'(1)) == times_q;
  assign unused_bits = ^{prod[W-1:0], prod[2*MW-1:2*W+2]};
  assign rd_x        = ({1'b0, rd_ch} < (CH_W+1)'(NCH)) ? x[rd_ch] : '0;
  always_comb begin
    a_m = state == S_M1S ? MW'(x[ch]) : mu_q;
    b_m = state == S_M1S ? ONE - MW'(x[ch]) : MW'(t_q);
`ifdef LOGISTIC_SAT_EN
    y_c = prod[2*W+2:W] > ONE ? ONE[XW-1:0] : prod[2*W:W];
`else
    y_c = prod[2*W:W];
`endif
  end
  logistic_seq_mult #(.MW(MW)) u_mult (
    .CLK(CLK), .RST(RST), .go(go), .a(a_m), .b(b_m), .prod(prod), .mult_done(mult_done)
  );
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      mu_q    <= '0;
      times_q <= '0;
      iter    <= '0;
      ch      <= '0;
      t_q     <= '0;
      y_q     <= '0;
      for (int i = 0; i < NCH; i++) x[i] <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          mu_q    <= mu;
          times_q <= times;
          busy    <= 1'b1;
          state   <= S_INIT;
        end
        S_INIT: begin
          for (int i = 0; i < NCH; i++) x[i] <= x0_base + XW'(i);
          ch    <= '0;
          iter  <= '0;
          done  <= times_q == '0;
          state <= times_q == '0 ? S_DONE : S_M1S;
        end
        S_M1S: state <= S_M1W;
        S_M1W: if (mult_done) begin
          t_q   <= prod[2*W+1:W];
          state <= S_M2S;
        end
        S_M2S: state <= S_M2W;
        S_M2W: if (mult_done) begin
          y_q   <= y_c;
          state <= S_WB;
        end
        S_WB: begin
          x[ch] <= y_q;
          ch    <= last ? '0 : ch + CH_W'(1);
          iter  <= last ? iter + ITER_W'(1) : iter;
          done  <= fin;
          state <= fin ? S_DONE : S_M1S;
        end
        S_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_logistic_array_engine.sv
// tb_logistic_array_engine: directed and seeded runs checked against an arithmetic reference model
module tb_logistic_array_engine;
  localparam int NCH = 7;
  localparam int S = 41;
  localparam longint ONE = 64'h10000;
  logic        CLK, RST, start;
  logic [18:0] mu;
  logic [8:0]  times;
  logic [16:0] x0_base;
  logic        busy, done;
  logic [2:0]  rd_ch;
  logic [16:0] rd_x;
  int total = 0, bad = 0, cyc = 0, start_cyc = -100000, run_len = 0, done_first = -1;
  bit chk_en = 0;
  longint exp_x [NCH];

  logistic_array_engine #(.W(16), .NCH(NCH), .ITER_W(9)) dut (
    .CLK(CLK), .RST(RST), .start(start), .mu(mu), .times(times), .x0_base(x0_base),
    .busy(busy), .done(done), .rd_ch(rd_ch), .rd_x(rd_x)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) if (chk_en) begin
    chk($sformatf("busy@%0d", cyc - start_cyc), 64'(busy),
        64'(cyc >= start_cyc + 1 && cyc <= start_cyc + run_len));
    chk($sformatf("done@%0d", cyc - start_cyc), 64'(done), 64'(cyc == start_cyc + run_len));
    if (done && done_first < 0) done_first = cyc - start_cyc;
  end

  // reference: x' = mu * ((x * (1-x)) >> W) >> W with the stated truncations
  task automatic model(input longint m, input int tm, input longint x0);
    longint b, t, p, y;
    for (int c = 0; c < NCH; c++) exp_x[c] = (x0 + c) & 64'h1ffff;
    for (int k = 0; k < tm; k++)
      for (int c = 0; c < NCH; c++) begin
        b = (ONE - exp_x[c]) & 64'h7ffff;
        t = ((exp_x[c] * b) >> 16) & 64'h3ffff;
        p = m * t;
        y = (p >> 16) & 64'h1ffff;
`ifdef LOGISTIC_SAT_EN
        if (((p >> 16) & 64'h7ffff) > ONE) y = ONE;
`endif
        exp_x[c] = y;
      end
  endtask

  task automatic run(input logic [18:0] m, input int tm, input logic [16:0] x0, input bit noisy);
    @(negedge CLK);
    mu = m; times = 9'(tm); x0_base = x0; start = 1;
    run_len = 2 + tm * NCH * S; start_cyc = cyc; done_first = -1; chk_en = 1;
    @(negedge CLK);
    start = 0;
    while (cyc <= start_cyc + run_len + 1) begin
      @(negedge CLK);
      start = noisy && (cyc == start_cyc + 50 || cyc == start_cyc + 400);
      if (start) begin mu = 19'h7ffff; times = 9'd1; x0_base = '0; end
    end
    model(m, tm, x0);
    chk("done_cycle", 64'(done_first), 64'(run_len));
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      rd_ch = 3'(c);
      #1;
      chk($sformatf("%s rd_x[%0d]", tag, c), 64'(rd_x), c < NCH ? exp_x[c] : 0);
    end
  endtask

  task automatic rdl(input string nm, input int c, input logic [63:0] e);
    @(negedge CLK);
    rd_ch = 3'(c);
    #1;
    chk(nm, 64'(rd_x), e);
  endtask

  initial begin
    RST = 0; start = 0; mu = '0; times = '0; x0_base = '0; rd_ch = '0;
    repeat (3) @(negedge CLK);
    RST = 1;
    chk("rst busy", 64'(busy), 0);
    chk("rst done", 64'(done), 0);
    for (int c = 0; c < NCH; c++) exp_x[c] = 0;
    check_all("rst");
    chk_en = 1;

    run(19'h40000, 0, 17'h08000, 0);
    check_all("t0");
    rdl("t0 lit ch6", 6, 64'h08006);
    chk("t0 done lit", 64'(done_first), 64'd2);

    run(19'h40000, 1, 17'h08000, 0);
    check_all("mu4 t1");
    rdl("mu4 t1 lit", 0, 64'h10000);
    chk("model pin mu4", 64'(exp_x[0]), 64'h10000);

    run(19'h40000, 2, 17'h08000, 0);
    check_all("mu4 t2");
    rdl("mu4 t2 lit", 0, 64'h00000);

    run(19'h60000, 1, 17'h08000, 0);
    check_all("mu6");
`ifdef LOGISTIC_SAT_EN
    rdl("mu6 lit", 0, 64'h10000);
`else
    rdl("mu6 lit", 0, 64'h18000);
`endif

    run(19'h3a000, 3, 17'h01000, 1);
    check_all("t3 noisy");
    chk("t3 done lit", 64'(done_first), 64'd863);

    chk_en = 0;
    @(negedge CLK);
    mu = 19'h38000; times = 9'd2; x0_base = 17'h04000; start = 1;
    @(negedge CLK);
    start = 0;
    repeat (98) @(negedge CLK);
    RST = 0;
    @(negedge CLK);
    RST = 1;
    chk("midrst busy", 64'(busy), 0);
    chk("midrst done", 64'(done), 0);
    for (int c = 0; c < NCH; c++) exp_x[c] = 0;
    check_all("midrst");
    run(19'h38000, 2, 17'h04000, 0);
    check_all("after rst");

    for (int r = 0; r < 4; r++) begin
      logic [18:0] m;
      logic [16:0] x0;
      int tm;
      m = 19'($urandom_range(0, 32'h3ffff));
      x0 = 17'($urandom_range(0, 32'h10000 - NCH + 1));
      tm = $urandom_range(1, 20);
      run(m, tm, x0, 0);
      check_all($sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
